block_sender: RTL
=================

BLOCK_SENDER -- requirements
Module: block_sender

Interface
REQ-001 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have loadValid  input  1  host offers one 352-bit work unit.
REQ-004 SHALL have loadData  input  352  work unit; [351:96] midstate, [95:0] header tail.
REQ-005 SHALL have loadReady  output  1  block can accept a work unit this cycle.
REQ-006 SHALL have pause  input  1  freezes the outgoing byte stream while high.
REQ-007 SHALL have writeValid  output  1  blockData carries a valid beat this cycle; drives blockStoreIfc.writeValid.
REQ-008 SHALL have blockData  output  8  current beat; drives blockStoreIfc.blockData.
REQ-009 SHALL have blockDone  output  1  one-cycle pulse coincident with the final beat of a unit.
REQ-010 SHALL have blocksSent  output  16  count of completed units; wraps modulo 2^16.

Function
REQ-011 SHALL serialize each unit as 44 beats of 8 bits, beat 0 = loadData[351:344], beat 43 = loadData[7:0].
REQ-012 SHALL hold one unit in a shifter and at most one in a pending buffer; loadReady = !pendingFull (combinational).
REQ-013 SHALL accept a unit on an edge where loadValid && loadReady; loadData not sampled otherwise.
REQ-014 SHALL use states IDLE (shifter empty) and SEND (shifter holds a unit); beat counter 6 bits, 0..43.
REQ-015 SHALL load the shifter when it is free or finishing beat 43 on this edge: from pending if full, else directly from an accepted unit; otherwise the accepted unit goes to pending.
REQ-016 SHALL register writeValid/blockData: on an edge in SEND with pause low, writeValid<=1, blockData<=current beat, counter advances; else writeValid<=0, blockData holds.
REQ-017 SHALL present beat 0 in the cycle after the edge that loaded the shifter (unit accepted in IDLE at edge k -> shifter loaded at k, writeValid=1 with beat 0 after edge k+1).
REQ-018 SHALL, when a next unit is available at beat 43, emit its beat 0 in the immediately following cycle (no idle gap between units).
REQ-019 SHALL freeze counter, shifter, and blockData while pause is high; resumed beat index continues unchanged; loads still accepted into pending.
REQ-020 SHALL assert blockDone in exactly the cycle writeValid carries beat 43, and increment blocksSent on that same edge (0xFFFF -> 0x0000).
REQ-021 SHALL return to IDLE after beat 43 when pending is empty and no unit is accepted on that edge.
REQ-022 SHALL, with pending full and shifter busy, hold loadReady=0 until the shifter loads from pending, then assert loadReady the following cycle.

Reset
REQ-023 SHALL, on any edge with rst high, force IDLE, counter=0, pendingFull=0, writeValid=0, blockData=0, blockDone=0, blocksSent=0.
REQ-024 SHALL ignore loadValid and pause on edges with rst high; loadReady=1 after the reset edge.
REQ-025 SHALL abandon a unit mid-stream on reset with no further beats and no blockDone for it.

Verification
REQ-026 Single unit: load all-ones in IDLE, pause=0 -> 44 consecutive writeValid beats of 0xFF, blockDone on 44th, blocksSent=1, then writeValid=0.
REQ-027 Ordering: load 352'h0102...2C (byte i = i+1) -> blockData sequence 0x01..0x2C in order.
REQ-028 Back-to-back: load A, then B while A sends, then C -> loadReady=0 with B pending; A beat 43 followed directly by B beat 0; C accepted after B moves to shifter.
REQ-029 Pause: raise pause for 5 cycles after beat 10 -> writeValid=0 for 5 cycles, blockData holds beat 10 value, resumes with beat 11; total 44 beats.
REQ-030 Reset mid-stream: assert rst for 1 cycle at beat 20 with pending full -> writeValid=0, no blockDone, blocksSent=0, loadReady=1; next load restarts at beat 0.
REQ-031 Wrap: preset by sending 65536 units (or force) -> blocksSent wraps 0xFFFF -> 0x0000 on final beat.

Source files
------------

// File: rtl/block_sender.sv
// Serializes 352-bit work units into 44 byte-wide beats, with one unit in flight
// and one parked in a pending buffer so consecutive units stream without gaps.
module block_sender (
    input  logic         clk,
    input  logic         rst,
    input  logic         loadValid,
    input  logic [351:0] loadData,
    output logic         loadReady,
    input  logic         pause,
    output logic         writeValid,
    output logic [7:0]   blockData,
    output logic         blockDone,
    output logic [15:0]  blocksSent
);
    localparam int         UNIT_W    = 352;
    localparam int         DATA_W    = 8;
    localparam logic [5:0] LAST_BEAT = 6'd43;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state;
    state_t            next_state;
    logic [UNIT_W-1:0] shifter;
    logic [UNIT_W-1:0] pending;
    logic              pendingFull;
    logic [5:0]        beat;

    logic accept;
    logic emit;
    logic finishing;
    logic shifter_free;
    logic load_from_pending;
    logic load_direct;
    logic park;

    assign loadReady = !pendingFull;

    // The shifter may reload on the same edge that drives out beat 43, which is
    // what makes back-to-back units gapless.
    always_comb begin
        accept            = loadValid && loadReady;
        emit              = (state == SEND) && !pause;
        finishing         = emit && (beat == LAST_BEAT);
        shifter_free      = (state == IDLE) || finishing;
        load_from_pending = shifter_free && pendingFull;
        load_direct       = shifter_free && !pendingFull && accept;
        park              = accept && !shifter_free;
        next_state        = state;
        if (load_from_pending || load_direct) begin
            next_state = SEND;
        end else if (finishing) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat        <= '0;
            pendingFull <= 1'b0;
            writeValid  <= 1'b0;
            blockData   <= '0;
            blockDone   <= 1'b0;
            blocksSent  <= '0;
        end else begin
            writeValid <= emit;
            blockDone  <= finishing;
            if (emit) begin
                blockData <= shifter[UNIT_W-1 -: DATA_W];
                beat      <= beat + 6'd1;
            end
            if (finishing) begin
                blocksSent <= blocksSent + 16'd1;
            end
            if (load_from_pending || load_direct) begin
                beat <= '0;
            end
            if (load_from_pending) begin
                pendingFull <= 1'b0;
            end else if (park) begin
                pendingFull <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; it is only observed once control says it is valid.
    always_ff @(posedge clk) begin
        if (load_from_pending) begin
            shifter <= pending;
        end else if (load_direct) begin
            shifter <= loadData;
        end else if (emit) begin
            shifter <= {shifter[UNIT_W-DATA_W-1:0], {DATA_W{1'b0}}};
        end
        if (park) begin
            pending <= loadData;
        end
    end
endmodule
